pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Central stall/flush controller for the 5-stage MIPS pipeline. It sequences multi-cycle data-memory accesses from the MEM stage over a req/ack handshake. It detects load-use hazards and resolves taken-branch flushes. It drives the stall (hold) and clr controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in ACCESS without ack before forced abort (1..2^CNT_W-1)
CNT_W, 8, width of the ack-wait counter

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
valid_mem_i  in  1  MEM-stage instruction valid
mem_to_reg_mem_i  in  1  MEM-stage instruction is a load
mem_wr_mem_i  in  1  MEM-stage instruction is a store
dmem_ack_i  in  1  data memory completes the current access
dmem_req_o  out  1  data memory request, held until ack
dmem_we_o  out  1  write enable qualifying dmem_req_o
valid_ex_i  in  1  EX-stage instruction valid
mem_to_reg_ex_i  in  1  EX-stage instruction is a load
rd_ex_i  in  5  EX-stage destination register
rs_id_i  in  5  ID-stage source register 1
rt_id_i  in  5  ID-stage source register 2
branch_taken_i  in  1  branch or jump resolved taken in EX
stall_fetch_o  out  1  hold PC and IF/ID
stall_decode_o  out  1  hold ID/EX
stall_execute_o  out  1  hold EX/MEM
clr_decode_o  out  1  clear IF/ID (bubble)
clr_execute_o  out  1  clear ID/EX (bubble)
clr_wb_o  out  1  clear MEM/WB (bubble)
busy_o  out  1  FSM not IDLE
timeout_o  out  1  sticky: an access was aborted by timeout
stall_cnt_o  out  16  cycles with stall_fetch_o=1, saturating

Behaviour:
- Reset (reset=0, async): FSM=IDLE, wait counter=0, timeout_o=0, stall_cnt_o=0. dmem_req_o and dmem_we_o drop immediately. All stall/clr outputs are 0 while in reset.
- mem_op = valid_mem_i & (mem_to_reg_mem_i | mem_wr_mem_i).
- FSM states IDLE, ACCESS, DONE. State outputs dmem_req_o, dmem_we_o and busy_o are registered (Moore).
- IDLE: if mem_op, go to ACCESS next edge and latch we = mem_wr_mem_i. Otherwise stay in IDLE.
- ACCESS: dmem_req_o=1, dmem_we_o=latched we. The counter increments each cycle.
  - dmem_ack_i=1: go to DONE and clear the counter.
  - No ack and counter reaches TIMEOUT_CYCLES-1: go to DONE, set timeout_o (sticky until reset), clear the counter.
- DONE: dmem_req_o=0 and mem_stall=0, so the MEM instruction advances this cycle. Always go to IDLE next edge. Back-to-back memory ops therefore have a minimum 1-cycle gap.
- mem_stall = (IDLE & mem_op) | ACCESS. This is combinational.
- Cost of an access: ack seen k cycles after the first req cycle (k≥0) gives k+2 stall cycles.
- Load-use: lu = valid_ex_i & mem_to_reg_ex_i & rd_ex_i≠0 & (rd_ex_i==rs_id_i | rd_ex_i==rt_id_i).
- Output priority, highest first:
  1. mem_stall: stall_fetch/decode/execute=1, clr_wb_o=1, all other clr=0. Branch and load-use are ignored; upstream inputs are frozen, so they re-evaluate afterwards.
  2. branch_taken_i: clr_decode_o=1, clr_execute_o=1, no stalls. This overrides lu because the dependent ID instruction is squashed.
  3. lu: stall_fetch_o=1, stall_decode_o=0, clr_execute_o=1. Exactly one bubble per hazard; the next cycle the load is in MEM and lu is false.
  4. Otherwise all stall/clr outputs are 0.
- clr_wb_o is asserted only under mem_stall.
- stall_cnt_o increments on every edge where stall_fetch_o=1 and holds at 16'hFFFF.
- Ack outside ACCESS is ignored.
- Reset asserted in ACCESS aborts the access with no timeout flag.

Test Plan:
- Load in MEM, ack 3 cycles after req rises -> dmem_req_o high 4 cycles, dmem_we_o=0, stall_fetch_o high 5 cycles, stall_cnt_o=5, FSM back to IDLE.
- Store with ack in the first ACCESS cycle -> req high 1 cycle, dmem_we_o=1, 2 stall cycles, clr_wb_o high in the same 2 cycles.
- TIMEOUT_CYCLES=4 and no ack -> req high exactly 4 cycles, then DONE, timeout_o=1 and stays 1 through later successful accesses until reset.
- EX load with rd_ex_i=5, rt_id_i=5 -> one cycle with stall_fetch_o=1, clr_execute_o=1. With rd_ex_i=0 -> no stall.
- branch_taken_i together with load-use (rd_ex_i=rs_id_i=7) -> clr_decode_o=1, clr_execute_o=1, stall_fetch_o=0. Branch during an ACCESS wait -> only stalls and clr_wb_o until DONE.
- Drive reset=0 mid-ACCESS -> dmem_req_o drops asynchronously, busy_o=0, stall_cnt_o=0. After release, the pending mem_op restarts from IDLE. 70000 stall cycles -> stall_cnt_o=16'hFFFF.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: sequences multi-cycle data-memory
// accesses over req/ack and resolves load-use and taken-branch hazards.
module pipe_stall_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_mem_i,
    input  logic        mem_to_reg_mem_i,
    input  logic        mem_wr_mem_i,
    input  logic        dmem_ack_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    input  logic        valid_ex_i,
    input  logic        mem_to_reg_ex_i,
    input  logic [4:0]  rd_ex_i,
    input  logic [4:0]  rs_id_i,
    input  logic [4:0]  rt_id_i,
    input  logic        branch_taken_i,
    output logic        stall_fetch_o,
    output logic        stall_decode_o,
    output logic        stall_execute_o,
    output logic        clr_decode_o,
    output logic        clr_execute_o,
    output logic        clr_wb_o,
    output logic        busy_o,
    output logic        timeout_o,
    output logic [15:0] stall_cnt_o
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              timeout_q, timeout_d;
    logic [15:0]       stall_cnt_q;

    logic mem_op;
    logic mem_stall;
    logic load_use;

    assign mem_op   = valid_mem_i & (mem_to_reg_mem_i | mem_wr_mem_i);
    assign load_use = valid_ex_i & mem_to_reg_ex_i & (rd_ex_i != 5'd0) &
                      ((rd_ex_i == rs_id_i) | (rd_ex_i == rt_id_i));
    assign mem_stall = ((state_q == StIdle) & mem_op) | (state_q == StAccess);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StIdle: begin
                if (mem_op) begin
                    state_d = StAccess;
                    we_d    = mem_wr_mem_i;
                    cnt_d   = '0;
                end
            end
            StAccess: begin
                if (dmem_ack_i) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            timeout_q <= timeout_d;
            if (stall_fetch_o && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    // Hazard outputs are forced low while reset is held, even if mem_op is pending.
    always_comb begin
        stall_fetch_o   = 1'b0;
        stall_decode_o  = 1'b0;
        stall_execute_o = 1'b0;
        clr_decode_o    = 1'b0;
        clr_execute_o   = 1'b0;
        clr_wb_o        = 1'b0;
        if (reset) begin
            if (mem_stall) begin
                stall_fetch_o   = 1'b1;
                stall_decode_o  = 1'b1;
                stall_execute_o = 1'b1;
                clr_wb_o        = 1'b1;
            end else if (branch_taken_i) begin
                clr_decode_o  = 1'b1;
                clr_execute_o = 1'b1;
            end else if (load_use) begin
                stall_fetch_o = 1'b1;
                clr_execute_o = 1'b1;
            end
        end
    end

    assign dmem_req_o  = (state_q == StAccess);
    assign dmem_we_o   = (state_q == StAccess) & we_q;
    assign busy_o      = (state_q != StIdle);
    assign timeout_o   = timeout_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl (TIMEOUT_CYCLES=4).
module tb_pipe_stall_ctrl;

    logic        clk;
    logic        reset;
    logic        valid_mem_i;
    logic        mem_to_reg_mem_i;
    logic        mem_wr_mem_i;
    logic        dmem_ack_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic        valid_ex_i;
    logic        mem_to_reg_ex_i;
    logic [4:0]  rd_ex_i;
    logic [4:0]  rs_id_i;
    logic [4:0]  rt_id_i;
    logic        branch_taken_i;
    logic        stall_fetch_o;
    logic        stall_decode_o;
    logic        stall_execute_o;
    logic        clr_decode_o;
    logic        clr_execute_o;
    logic        clr_wb_o;
    logic        busy_o;
    logic        timeout_o;
    logic [15:0] stall_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_stall_ctrl #(
        .TIMEOUT_CYCLES(4),
        .CNT_W         (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .valid_mem_i     (valid_mem_i),
        .mem_to_reg_mem_i(mem_to_reg_mem_i),
        .mem_wr_mem_i    (mem_wr_mem_i),
        .dmem_ack_i      (dmem_ack_i),
        .dmem_req_o      (dmem_req_o),
        .dmem_we_o       (dmem_we_o),
        .valid_ex_i      (valid_ex_i),
        .mem_to_reg_ex_i (mem_to_reg_ex_i),
        .rd_ex_i         (rd_ex_i),
        .rs_id_i         (rs_id_i),
        .rt_id_i         (rt_id_i),
        .branch_taken_i  (branch_taken_i),
        .stall_fetch_o   (stall_fetch_o),
        .stall_decode_o  (stall_decode_o),
        .stall_execute_o (stall_execute_o),
        .clr_decode_o    (clr_decode_o),
        .clr_execute_o   (clr_execute_o),
        .clr_wb_o        (clr_wb_o),
        .busy_o          (busy_o),
        .timeout_o       (timeout_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hazards();
        valid_ex_i      = 1'b0;
        mem_to_reg_ex_i = 1'b0;
        rd_ex_i         = 5'd0;
        rs_id_i         = 5'd0;
        rt_id_i         = 5'd0;
        branch_taken_i  = 1'b0;
    endtask

    // Runs one MEM-stage access; ack is raised on the req cycle with index ack_k (-1: never).
    task automatic mem_access(input logic is_store, input int ack_k, output int n_req,
                              output int n_stall, output int n_clrwb, output int n_we,
                              output logic finished);
        n_req    = 0;
        n_stall  = 0;
        n_clrwb  = 0;
        n_we     = 0;
        finished = 1'b0;
        valid_mem_i      = 1'b1;
        mem_to_reg_mem_i = ~is_store;
        mem_wr_mem_i     = is_store;
        for (int c = 0; c < 20 && !finished; c++) begin
            dmem_ack_i = dmem_req_o && (n_req == ack_k);
            #1;
            if (dmem_req_o)    n_req++;
            if (dmem_we_o)     n_we++;
            if (stall_fetch_o) n_stall++;
            if (clr_wb_o)      n_clrwb++;
            if (busy_o && !dmem_req_o) finished = 1'b1;
            step();
        end
        valid_mem_i      = 1'b0;
        mem_to_reg_mem_i = 1'b0;
        mem_wr_mem_i     = 1'b0;
        dmem_ack_i       = 1'b0;
    endtask

    int   n_req, n_stall, n_clrwb, n_we;
    logic fin;

    initial begin
        reset            = 1'b0;
        valid_mem_i      = 1'b1;
        mem_to_reg_mem_i = 1'b1;
        mem_wr_mem_i     = 1'b0;
        dmem_ack_i       = 1'b0;
        clear_hazards();
        #1;
        check("rst_stall_fetch", {31'b0, stall_fetch_o}, 32'd0);
        check("rst_clr_wb", {31'b0, clr_wb_o}, 32'd0);
        check("rst_req", {31'b0, dmem_req_o}, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_timeout", {31'b0, timeout_o}, 32'd0);
        check("rst_stall_cnt", {16'b0, stall_cnt_o}, 32'd0);
        valid_mem_i      = 1'b0;
        mem_to_reg_mem_i = 1'b0;
        step();
        reset = 1'b1;
        step();

        // Load, ack 3 cycles after req rises
        mem_access(1'b0, 3, n_req, n_stall, n_clrwb, n_we, fin);
        check("ld_done", {31'b0, fin}, 32'd1);
        check("ld_req_cycles", n_req, 32'd4);
        check("ld_we_cycles", n_we, 32'd0);
        check("ld_stall_cycles", n_stall, 32'd5);
        check("ld_stall_cnt", {16'b0, stall_cnt_o}, 32'd5);
        check("ld_idle", {31'b0, busy_o}, 32'd0);

        // Store, ack in first ACCESS cycle
        mem_access(1'b1, 0, n_req, n_stall, n_clrwb, n_we, fin);
        check("st_done", {31'b0, fin}, 32'd1);
        check("st_req_cycles", n_req, 32'd1);
        check("st_we_cycles", n_we, 32'd1);
        check("st_stall_cycles", n_stall, 32'd2);
        check("st_clrwb_cycles", n_clrwb, 32'd2);
        check("st_stall_cnt", {16'b0, stall_cnt_o}, 32'd7);
        check("st_no_timeout", {31'b0, timeout_o}, 32'd0);

        // Load-use: rd=5 matches rt
        valid_ex_i      = 1'b1;
        mem_to_reg_ex_i = 1'b1;
        rd_ex_i         = 5'd5;
        rt_id_i         = 5'd5;
        rs_id_i         = 5'd3;
        #1;
        check("lu_stall_fetch", {31'b0, stall_fetch_o}, 32'd1);
        check("lu_stall_decode", {31'b0, stall_decode_o}, 32'd0);
        check("lu_clr_execute", {31'b0, clr_execute_o}, 32'd1);
        check("lu_clr_decode", {31'b0, clr_decode_o}, 32'd0);
        check("lu_clr_wb", {31'b0, clr_wb_o}, 32'd0);
        step();
        check("lu_stall_cnt", {16'b0, stall_cnt_o}, 32'd8);

        // rd=0 never hazards even when sources are r0
        rd_ex_i = 5'd0;
        rt_id_i = 5'd0;
        rs_id_i = 5'd0;
        #1;
        check("lu_r0_stall", {31'b0, stall_fetch_o}, 32'd0);
        check("lu_r0_clr_ex", {31'b0, clr_execute_o}, 32'd0);

        // Branch overrides load-use
        rd_ex_i        = 5'd7;
        rs_id_i        = 5'd7;
        branch_taken_i = 1'b1;
        #1;
        check("br_lu_clr_decode", {31'b0, clr_decode_o}, 32'd1);
        check("br_lu_clr_execute", {31'b0, clr_execute_o}, 32'd1);
        check("br_lu_stall_fetch", {31'b0, stall_fetch_o}, 32'd0);
        step();

        // Branch during an ACCESS wait
        valid_mem_i      = 1'b1;
        mem_to_reg_mem_i = 1'b1;
        step();
        check("br_acc_req", {31'b0, dmem_req_o}, 32'd1);
        check("br_acc_stall", {31'b0, stall_fetch_o}, 32'd1);
        check("br_acc_clr_wb", {31'b0, clr_wb_o}, 32'd1);
        check("br_acc_clr_decode", {31'b0, clr_decode_o}, 32'd0);
        check("br_acc_clr_execute", {31'b0, clr_execute_o}, 32'd0);
        dmem_ack_i = 1'b1;
        step();
        dmem_ack_i = 1'b0;
        #1;
        check("br_done_busy", {31'b0, busy_o}, 32'd1);
        check("br_done_clr_wb", {31'b0, clr_wb_o}, 32'd0);
        check("br_done_clr_decode", {31'b0, clr_decode_o}, 32'd1);
        step();
        valid_mem_i      = 1'b0;
        mem_to_reg_mem_i = 1'b0;
        clear_hazards();

        // Timeout with no ack, then sticky through a good access
        mem_access(1'b0, -1, n_req, n_stall, n_clrwb, n_we, fin);
        check("to_done", {31'b0, fin}, 32'd1);
        check("to_req_cycles", n_req, 32'd4);
        check("to_stall_cycles", n_stall, 32'd5);
        check("to_flag", {31'b0, timeout_o}, 32'd1);
        mem_access(1'b1, 1, n_req, n_stall, n_clrwb, n_we, fin);
        check("to_next_req", n_req, 32'd2);
        check("to_sticky", {31'b0, timeout_o}, 32'd1);

        // Reset mid-ACCESS
        valid_mem_i      = 1'b1;
        mem_to_reg_mem_i = 1'b1;
        step();
        step();
        check("mid_req_before", {31'b0, dmem_req_o}, 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_req", {31'b0, dmem_req_o}, 32'd0);
        check("mid_rst_busy", {31'b0, busy_o}, 32'd0);
        check("mid_rst_stall_cnt", {16'b0, stall_cnt_o}, 32'd0);
        check("mid_rst_stall", {31'b0, stall_fetch_o}, 32'd0);
        check("mid_rst_timeout", {31'b0, timeout_o}, 32'd0);
        step();
        reset = 1'b1;
        #1;
        check("restart_idle_stall", {31'b0, stall_fetch_o}, 32'd1);
        check("restart_idle_req", {31'b0, dmem_req_o}, 32'd0);
        step();
        check("restart_req", {31'b0, dmem_req_o}, 32'd1);
        dmem_ack_i = 1'b1;
        step();
        dmem_ack_i       = 1'b0;
        valid_mem_i      = 1'b0;
        mem_to_reg_mem_i = 1'b0;
        step();
        check("restart_idle", {31'b0, busy_o}, 32'd0);
        check("restart_no_timeout", {31'b0, timeout_o}, 32'd0);

        // Stall counter saturation via a held load-use hazard
        reset = 1'b0;
        #1;
        reset           = 1'b1;
        valid_ex_i      = 1'b1;
        mem_to_reg_ex_i = 1'b1;
        rd_ex_i         = 5'd9;
        rs_id_i         = 5'd9;
        #1;
        repeat (65534) @(posedge clk);
        #1;
        check("sat_below", {16'b0, stall_cnt_o}, 32'h0000_FFFE);
        repeat (4500) @(posedge clk);
        #1;
        check("sat_hold", {16'b0, stall_cnt_o}, 32'h0000_FFFF);
        clear_hazards();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
